timed_button_state_machine: RTL and testbench
=============================================

// Module: timed_button_state_machine
// PURPOSE
//  Parametrised button-driven state sequencer for the board UI path: LEFT/RIGHT walk a ring of N_STATES, CENTRE returns HOME.
//  Adds edge-qualified buttons, a per-state dwell timer with auto-return, and HOLD/STEP/CLEAR modes via MASTER_CONTROL.
//  Sits between the debounced button block and the 7-segment/LED display driver (STATE_OUT).
// PARAMETERS
//  N_STATES       8     number of states in ring, 2..2^STATE_W
//  STATE_W        3     state register width
//  OUT_W          4     STATE_OUT width, >= STATE_W (zero-extended)
//  HOME_STATE     0     reset/CENTRE/timeout target, < N_STATES
//  TIMEOUT_CYCLES 1000  dwell limit in CLK cycles, 2..2^TIMER_W-1
//  TIMER_W        16    dwell timer width
//  CNT_W          8     transition counter width
// PORTS
//  CLK             in   1        system clock, rising edge
//  RESET           in   1        asynchronous, active-low reset
//  BTN_LEFT        in   1        debounced, CLK-synchronous level
//  BTN_CENTRE      in   1        debounced, CLK-synchronous level
//  BTN_RIGHT       in   1        debounced, CLK-synchronous level
//  MASTER_CONTROL  in   2        0=RUN 1=HOLD 2=STEP 3=CLEAR
//  STATE_OUT       out  OUT_W    current state, zero-extended, registered
//  STATE_CHANGE    out  1        1-cycle pulse, coincident with STATE_OUT change
//  TIMEOUT         out  1        1-cycle pulse, coincident with RUN auto-return
//  TRANS_COUNT     out  CNT_W    accepted transitions, saturating
// BEHAVIOUR
//  - Reset (RESET=0, async): state=HOME_STATE, timer=0, TRANS_COUNT=0, STATE_CHANGE=0, TIMEOUT=0, button history=3'b111 (held buttons do not fire on release of reset).
//  - Edge detect: ev_x = BTN_x & ~btn_q_x; btn_q updates every cycle in all modes. Only rising edges act.
//  - Latency: edge sampled at CLK edge k -> STATE_OUT new value after edge k (1 cycle); no hold of level re-fires.
//  - Simultaneous edges: priority CENTRE > LEFT > RIGHT; lower-priority edges discarded.
//  - RUN: CENTRE->HOME; LEFT->state-1 (0 wraps to N_STATES-1); RIGHT->state+1 (N_STATES-1 wraps to 0).
//  - Timer counts cycles in current state; cleared on any state change, any MASTER_CONTROL change, or accepted edge.
//  - RUN timeout: timer==TIMEOUT_CYCLES-1 and no edge and state!=HOME -> state=HOME, TIMEOUT=1, STATE_CHANGE=1. At HOME timer saturates at TIMEOUT_CYCLES-1, no pulse.
//  - Edge and timeout same cycle: edge wins, TIMEOUT=0.
//  - HOLD: state, timer, count frozen; all edges discarded; outputs pulses 0.
//  - STEP: LEFT/RIGHT ignored; CENTRE->HOME; timer==TIMEOUT_CYCLES-1 -> state+1 with wrap, STATE_CHANGE=1, TIMEOUT=0.
//  - CLEAR: synchronous: state=HOME, timer=0, TRANS_COUNT=0; STATE_CHANGE=1 only if state was !=HOME; edges discarded.
//  - Edge targeting current state (e.g. CENTRE at HOME): accepted, timer cleared, no STATE_CHANGE, no count.
//  - STATE_CHANGE=1 iff registered state differs from previous cycle; TRANS_COUNT increments on each STATE_CHANGE except CLEAR, saturates at 2^CNT_W-1.
//  - States >= N_STATES unreachable; if ever loaded, next cycle forces HOME with STATE_CHANGE=1.
// CONFIGURATION
//  TRANS_COUNTER_EN defined: counter implemented as above.
//  TRANS_COUNTER_EN undefined: no counter flops; TRANS_COUNT tied to 0; all other behaviour identical.
// TESTING (N_STATES=8, HOME_STATE=0, TIMEOUT_CYCLES=16, TRANS_COUNTER_EN defined)
//  1. Reset release, RUN, RIGHT pulse x3 -> STATE_OUT 1,2,3 one cycle after each edge; STATE_CHANGE x3; TRANS_COUNT=3.
//  2. State 0, LEFT edge -> STATE_OUT=7 (wrap); RIGHT held 20 cycles from state 7 -> one step to 0 only.
//  3. RUN at state 3, idle 16 cycles -> STATE_OUT=0 with TIMEOUT=1 and STATE_CHANGE=1 same cycle; RIGHT edge on cycle 16 instead -> state 4, TIMEOUT=0.
//  4. LEFT+CENTRE+RIGHT edges same cycle at state 5 -> STATE_OUT=0; HOLD then RIGHT edge -> no change, timer frozen.
//  5. STEP from state 6 -> 7 after 16 cycles, 0 after 32; then CLEAR at state 2 -> state 0, TRANS_COUNT=0, one STATE_CHANGE.
//  6. RESET low mid-timer at state 4 with BTN_RIGHT held -> immediate state 0, outputs 0; RESET high with button still held -> no transition.

Source files
------------

// File: rtl/timed_button_state_machine.sv
// timed_button_state_machine: button-driven ring sequencer with a dwell
// timer, auto-return to HOME and RUN/HOLD/STEP/CLEAR master modes.
// Define TRANS_COUNTER_EN to build the saturating transition counter;
// without it TRANS_COUNT is tied to zero and no counter flops exist.
module timed_button_state_machine #(
    parameter int N_STATES       = 8,
    parameter int STATE_W        = 3,
    parameter int OUT_W          = 4,
    parameter int HOME_STATE     = 0,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 16,
    parameter int CNT_W          = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BTN_LEFT,
    input  logic             BTN_CENTRE,
    input  logic             BTN_RIGHT,
    input  logic [1:0]       MASTER_CONTROL,
    output logic [OUT_W-1:0] STATE_OUT,
    output logic             STATE_CHANGE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] TRANS_COUNT
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_STEP  = 2'd2,
        MODE_CLEAR = 2'd3
    } mode_e;

    localparam logic [STATE_W-1:0] HOME  = STATE_W'(HOME_STATE);
    localparam logic [STATE_W-1:0] LAST  = STATE_W'(N_STATES - 1);
    localparam logic [STATE_W:0]   LIMIT = (STATE_W + 1)'(N_STATES);
    localparam logic [TIMER_W-1:0] T_END = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    // Button history, ordered {centre, left, right}
    logic [2:0]         btn_q;
    mode_e              mode_q;
    logic               change_q;
    logic               change_d;
    logic               timeout_q;
    logic               timeout_d;

    logic [2:0]         ev;
    mode_e              mode;
    logic               mode_chg;
    logic               expired;
    logic               bad_state;
    logic               accepted;
    logic [STATE_W-1:0] prev_state;
    logic [STATE_W-1:0] next_state;

    // Next-state, pulse and dwell-timer decisions for the current cycle
    always_comb begin
        mode       = mode_e'(MASTER_CONTROL);
        ev         = {BTN_CENTRE, BTN_LEFT, BTN_RIGHT} & ~btn_q;
        mode_chg   = mode != mode_q;
        expired    = timer_q == T_END;
        bad_state  = {1'b0, state_q} >= LIMIT;
        prev_state = (state_q == '0) ? LAST : state_q - 1'b1;
        next_state = (state_q == LAST) ? '0 : state_q + 1'b1;
        state_d    = state_q;
        timeout_d  = 1'b0;
        accepted   = 1'b0;

        if (bad_state) begin
            state_d = HOME;
        end else begin
            unique case (mode)
                MODE_RUN: begin
                    accepted = |ev;
                    if (ev[2]) begin
                        state_d = HOME;
                    end else if (ev[1]) begin
                        state_d = prev_state;
                    end else if (ev[0]) begin
                        state_d = next_state;
                    end else if (expired && state_q != HOME) begin
                        state_d   = HOME;
                        timeout_d = 1'b1;
                    end
                end
                MODE_HOLD: begin
                    state_d = state_q;
                end
                MODE_STEP: begin
                    accepted = ev[2];
                    if (ev[2]) begin
                        state_d = HOME;
                    end else if (expired) begin
                        state_d = next_state;
                    end
                end
                MODE_CLEAR: begin
                    state_d = HOME;
                end
            endcase
        end

        change_d = state_d != state_q;

        // HOLD freezes the dwell count; at its limit the count saturates
        if (mode == MODE_HOLD && !bad_state) begin
            timer_d = timer_q;
        end else if (mode == MODE_CLEAR || change_d || mode_chg || accepted) begin
            timer_d = '0;
        end else if (expired) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State, timer, history and registered pulse outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= HOME;
            timer_q   <= '0;
            btn_q     <= 3'b111;
            mode_q    <= MODE_RUN;
            change_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            btn_q     <= {BTN_CENTRE, BTN_LEFT, BTN_RIGHT};
            mode_q    <= mode;
            change_q  <= change_d;
            timeout_q <= timeout_d;
        end
    end

    assign STATE_OUT    = OUT_W'(state_q);
    assign STATE_CHANGE = change_q;
    assign TIMEOUT      = timeout_q;

`ifdef TRANS_COUNTER_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count state changes, saturating; CLEAR wipes the count
    always_comb begin
        cnt_d = cnt_q;
        if (mode == MODE_CLEAR && !bad_state) begin
            cnt_d = '0;
        end else if (change_d && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Transition counter register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TRANS_COUNT = cnt_q;
`else
    assign TRANS_COUNT = '0;
`endif

endmodule

// File: tb/tb_timed_button_state_machine.sv
// tb_timed_button_state_machine: directed scenarios plus random stimulus
// checked against an integer reference model of the sequencer.
module tb_timed_button_state_machine;

    localparam int N    = 8;
    localparam int SW   = 3;
    localparam int OW   = 4;
    localparam int HOME = 0;
    localparam int TO   = 16;
    localparam int TW   = 16;
    localparam int CW   = 8;
    localparam int VW   = OW + 2 + CW;
`ifdef TRANS_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          bl    = 1'b0;
    logic          bc    = 1'b0;
    logic          br    = 1'b0;
    logic [1:0]    mc    = 2'd0;
    logic [OW-1:0] so;
    logic          sc;
    logic          tmo;
    logic [CW-1:0] tc;
    logic [VW-1:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state, dwell cycles, count, button/mode history
    int ms;
    int mdw;
    int mcnt;
    int pmode;
    bit pl;
    bit pc;
    bit pr;
    bit e_chg;
    bit e_to;

    always #5 clk = ~clk;

    assign obs = {so, sc, tmo, tc};

    timed_button_state_machine #(
        .N_STATES(N), .STATE_W(SW), .OUT_W(OW), .HOME_STATE(HOME),
        .TIMEOUT_CYCLES(TO), .TIMER_W(TW), .CNT_W(CW)
    ) dut (
        .CLK(clk), .RESET(rst_n),
        .BTN_LEFT(bl), .BTN_CENTRE(bc), .BTN_RIGHT(br),
        .MASTER_CONTROL(mc),
        .STATE_OUT(so), .STATE_CHANGE(sc), .TIMEOUT(tmo),
        .TRANS_COUNT(tc)
    );

    task automatic m_reset();
        ms    = HOME;
        mdw   = 0;
        mcnt  = 0;
        pmode = 0;
        pl    = 1'b1;
        pc    = 1'b1;
        pr    = 1'b1;
        e_chg = 1'b0;
        e_to  = 1'b0;
    endtask

    // One clock of the sequencer rules, in plain integer arithmetic
    task automatic m_step(input bit l, input bit c, input bit r,
                          input int m);
        bit el, ec, er, mchg, acc, expd;
        int ns;
        el    = l && !pl;
        ec    = c && !pc;
        er    = r && !pr;
        pl    = l;
        pc    = c;
        pr    = r;
        mchg  = (m != pmode);
        pmode = m;
        expd  = (mdw == TO - 1);
        ns    = ms;
        acc   = 1'b0;
        e_to  = 1'b0;
        if (m == 0) begin
            acc = el || ec || er;
            if (ec) ns = HOME;
            else if (el) ns = (ms + N - 1) % N;
            else if (er) ns = (ms + 1) % N;
            else if (expd && ms != HOME) begin
                ns   = HOME;
                e_to = 1'b1;
            end
        end else if (m == 2) begin
            acc = ec;
            if (ec) ns = HOME;
            else if (expd) ns = (ms + 1) % N;
        end else if (m == 3) begin
            ns = HOME;
        end
        e_chg = (ns != ms);
        if (m == 3) mcnt = 0;
        else if (e_chg && mcnt < (1 << CW) - 1) mcnt++;
        if (m != 1) begin
            if (m == 3 || e_chg || mchg || acc) mdw = 0;
            else if (mdw < TO - 1) mdw++;
        end
        ms = ns;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {OW'(ms), e_chg, e_to, CW'(CNT_EN ? mcnt : 0)};
    endfunction

    // Drive inputs, take one clock, advance the model, settle
    task automatic cyc(input logic l, input logic c, input logic r,
                       input logic [1:0] m);
        bl = l;
        bc = c;
        br = r;
        mc = m;
        @(posedge clk);
        m_step(l, c, r, int'(m));
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0);
            n_checks++;
            if (obs !== exp_vec() || so !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: got %h want %h",
                         obs, exp_vec());
            end
        end
    endtask

    task automatic test_right_steps();
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 0);
            n_checks++;
            if (so !== OW'(i) || sc !== 1'b1 || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL right_step%0d: st=%0d chg=%0b want %0d 1",
                         i, so, sc, i);
            end
            cyc(0, 0, 0, 0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL right_idle%0d: got %h want %h",
                         i, obs, exp_vec());
            end
        end
        n_checks++;
        if (tc !== CW'(CNT_EN ? 3 : 0)) begin
            n_fail++;
            $display("FAIL right_count: got %0d want %0d",
                     tc, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_wrap_level();
        int pulses;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        n_checks++;
        if (so !== OW'(7) || sc !== 1'b1 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL left_wrap: st=%0d chg=%0b want 7 1", so, sc);
        end
        cyc(0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 0);
            if (sc === 1'b1) pulses++;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL right_held%0d: got %h want %h",
                         i, obs, exp_vec());
            end
        end
        n_checks++;
        if (pulses != 1 || so !== '0) begin
            n_fail++;
            $display("FAIL held_once: pulses=%0d st=%0d want 1 0",
                     pulses, so);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int bad;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        for (int j = 1; j <= 16; j++) begin
            cyc(0, 0, 0, 0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL dwell%0d: got %h want %h",
                         j, obs, exp_vec());
            end
        end
        n_checks++;
        if (so !== '0 || tmo !== 1'b1 || sc !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: st=%0d to=%0b chg=%0b want 0 1 1",
                     so, tmo, sc);
        end
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            cyc(0, 0, 0, 0);
            if (tmo !== 1'b0 || sc !== 1'b0 || so !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL home_saturate: got %0d bad cycles want 0", bad);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        for (int j = 1; j <= 15; j++) cyc(0, 0, 0, 0);
        n_checks++;
        if (so !== OW'(3) || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_edge: st=%0d to=%0b want 3 0", so, tmo);
        end
        cyc(0, 0, 1, 0);
        n_checks++;
        if (so !== OW'(4) || tmo !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL edge_beats_to: st=%0d to=%0b want 4 0", so, tmo);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_priority_hold();
        int bad;
        int wait_n;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 0);
        n_checks++;
        if (so !== '0 || sc !== 1'b1 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL priority: st=%0d chg=%0b want 0 1", so, sc);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        n_checks++;
        if (so !== OW'(1) || sc !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_edge: st=%0d chg=%0b want 1 0", so, sc);
        end
        bad = 0;
        for (int j = 0; j < 30; j++) begin
            cyc(0, 0, logic'(j < 10), 1);
            if (obs !== exp_vec() || so !== OW'(1) || sc !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_frozen: got %0d bad cycles want 0", bad);
        end
        wait_n = 0;
        do begin
            cyc(0, 0, 0, 0);
            wait_n++;
        end while (tmo !== 1'b1 && wait_n < 40);
        n_checks++;
        if (wait_n != 17 || so !== '0) begin
            n_fail++;
            $display("FAIL hold_exit_to: got %0d cycles st=%0d want 17 0",
                     wait_n, so);
        end
    endtask

    task automatic test_step_clear();
        int bad;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        bad = 0;
        for (int j = 1; j <= 65; j++) begin
            cyc(logic'(j == 9), 0, logic'(j == 5), 2);
            if (obs !== exp_vec()) bad++;
            if (j == 16 && so !== OW'(6)) bad++;
            if (j == 17 && (so !== OW'(7) || sc !== 1'b1)) bad++;
            if (j == 33 && (so !== '0 || tmo !== 1'b0)) bad++;
        end
        n_checks++;
        if (bad != 0 || so !== OW'(2)) begin
            n_fail++;
            $display("FAIL step_mode: bad=%0d st=%0d want 0 2", bad, so);
        end
        cyc(0, 0, 0, 3);
        n_checks++;
        if (so !== '0 || sc !== 1'b1 || tc !== '0) begin
            n_fail++;
            $display("FAIL clear: st=%0d chg=%0b cnt=%0d want 0 1 0",
                     so, sc, tc);
        end
        cyc(0, 0, 0, 3);
        n_checks++;
        if (sc !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_home: got %h want %h", obs, exp_vec());
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
        repeat (5) cyc(0, 0, 0, 0);
        n_checks++;
        if (so !== OW'(4)) begin
            n_fail++;
            $display("FAIL pre_reset: st=%0d want 4", so);
        end
        br    = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0);
            if (obs !== exp_vec() || so !== '0 || sc !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL held_through_reset: got %0d bad want 0", bad);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        n_checks++;
        if (so !== OW'(1) || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset_edge: st=%0d want 1", so);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 1, 0);
            if (obs !== exp_vec()) bad++;
            cyc(0, 0, 0, 0);
            if (obs !== exp_vec()) bad++;
        end
        n_checks++;
        if (bad != 0 || tc !== CW'(CNT_EN ? 255 : 0)) begin
            n_fail++;
            $display("FAIL saturate: bad=%0d cnt=%0d want 0 %0d",
                     bad, tc, CNT_EN ? 255 : 0);
        end
    endtask

    task automatic test_random();
        int  k;
        logic [1:0] m;
        logic l, c, r;
        m = 2'd0;
        l = 1'b0;
        c = 1'b0;
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                k = $urandom_range(0, 99);
                m = (k < 60) ? 2'd0 : (k < 75) ? 2'd1 :
                    (k < 92) ? 2'd2 : 2'd3;
            end
            if ($urandom_range(0, 99) < 10) l = ~l;
            if ($urandom_range(0, 99) < 5)  c = ~c;
            if ($urandom_range(0, 99) < 10) r = ~r;
            cyc(l, c, r, m);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random%0d: got %h want %h",
                         i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_right_steps();
        test_wrap_level();
        test_timeout();
        test_priority_hold();
        test_step_clear();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
